// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and types for the pipeline controller.
//   - default multiplier pipeline depth
//   - stage-bit indices into stall_o / flush_o
//   - FSM state encodings
//   - scoreboard slot type and a register-hit helper
package pipe_ctrl_pkg;

  // Multiplier pipeline depth in cycles (legal 2..8).
  localparam int MULT_PPL_STAGE_DEF = 3;

  // Bit positions in stall_o / flush_o, one per pipeline register.
  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

  // Control patterns built from the stage indices.
  localparam logic [4:0] CTRL_NONE      = 5'b00000;
  localparam logic [4:0] STALL_HAZARD   = (5'd1 << STG_PC) | (5'd1 << STG_IF_ID);
  localparam logic [4:0] FLUSH_HAZARD   = (5'd1 << STG_ID_EX);
  localparam logic [4:0] FLUSH_BRANCH   = (5'd1 << STG_IF_ID) | (5'd1 << STG_ID_EX);
  localparam logic [4:0] FLUSH_REDIRECT = (5'd1 << STG_IF_ID);
  // The back half of the pipe is never held or flushed by this controller.
  localparam logic [4:0] BACK_HALF_MASK = (5'd1 << STG_EX_MEM) | (5'd1 << STG_MEM_WB);

  // FSM state encodings.
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  // One in-flight multiply: destination register and a valid flag.
  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
  } mult_slot_t;

  localparam mult_slot_t SLOT_EMPTY = '{valid: 1'b0, addr: 5'd0};

  // True when an enabled, non-x0 register address is marked in mask.
  function automatic logic reg_hit(input logic en, input logic [4:0] addr,
                                   input logic [31:0] mask);
    return en && (addr != 5'd0) && mask[addr];
  endfunction

endpackage

// File: rtl/pipe_ctrl_scoreboard.sv
// mult_scoreboard: tracks multiplies in flight through the multiplier.
//   clk, rst         clock, async active-low reset
//   issue, rd        EX issues a multiply to rd this cycle
//   busy             per-register pending bit over all slots (bit0 = 0)
//   busy_early       pending bits of slots 0..STAGES-2 (result not yet forwardable)
//   wb_valid/addr    last slot: multiply result retiring this cycle
module mult_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = MULT_PPL_STAGE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic [4:0]  rd,
  output logic [31:0] busy,
  output logic [31:0] busy_early,
  output logic        wb_valid,
  output logic [4:0]  wb_addr
);

  mult_slot_t  slot_r [STAGES];
  logic [31:0] busy_s;
  logic [31:0] early_s;

  // Shift register of in-flight multiplies; advances every cycle regardless of stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        slot_r[i] <= SLOT_EMPTY;
      end
    end else begin
      // A multiply to x0 never produces a visible result, so it is not tracked.
      slot_r[0] <= '{valid: issue && (rd != 5'd0), addr: rd};
      for (int i = 1; i < STAGES; i++) begin
        slot_r[i] <= slot_r[i-1];
      end
    end
  end

  // Decode valid slots into per-register busy masks.
  always_comb begin
    busy_s  = 32'd0;
    early_s = 32'd0;
    for (int i = 0; i < STAGES; i++) begin
      busy_s  = busy_s | ({31'd0, slot_r[i].valid} << slot_r[i].addr);
      // The last slot is forwarded to ID, so it never causes a hazard.
      early_s = early_s | (((i < STAGES - 1) ? {31'd0, slot_r[i].valid} : 32'd0)
                           << slot_r[i].addr);
    end
  end

  assign busy       = busy_s & ~32'd1;
  assign busy_early = early_s & ~32'd1;
  assign wb_valid   = slot_r[STAGES-1].valid;
  assign wb_addr    = slot_r[STAGES-1].addr;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / redirect controller.
//   clk, rst                        clock, async active-low reset
//   rs1/rs2_re_id_i, *_addr_id_i    ID source register reads
//   rd_we_id_i, rd_addr_id_i        ID destination
//   load_ex_i, rd_addr_ex_i         load in EX and its destination
//   mult_issue_ex_i, mult_rd_ex_i   multiply issued from EX
//   branch_taken_ex_i               taken branch/jump resolved in EX
//   stall_o / flush_o               hold / bubble enables {MEM_WB,EX_MEM,ID_EX,IF_ID,PC}
//   mult_busy_o                     pending-multiply scoreboard
//   mult_wb_valid_o/addr_o          multiply result retiring this cycle
//   stall_cycles_o                  count of cycles with the PC held
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_PPL_STAGE   = MULT_PPL_STAGE_DEF,
  parameter int REDIRECT_BUBBLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rs1_re_id_i,
  input  logic        rs2_re_id_i,
  input  logic [4:0]  rs1_addr_id_i,
  input  logic [4:0]  rs2_addr_id_i,
  input  logic        rd_we_id_i,
  input  logic [4:0]  rd_addr_id_i,
  input  logic        load_ex_i,
  input  logic [4:0]  rd_addr_ex_i,
  input  logic        mult_issue_ex_i,
  input  logic [4:0]  mult_rd_ex_i,
  input  logic        branch_taken_ex_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic [31:0] mult_busy_o,
  output logic        mult_wb_valid_o,
  output logic [4:0]  mult_wb_addr_o,
  output logic [31:0] stall_cycles_o
);

  // Bubble counter reload; with a single bubble the branch cycle alone covers it.
  localparam logic [7:0] BUBBLE_RELOAD = 8'(REDIRECT_BUBBLES - 1);
  localparam logic [0:0] BRANCH_NEXT   = (REDIRECT_BUBBLES > 1) ? ST_REDIRECT : ST_RUN;

  logic [0:0]  state_r;
  logic [7:0]  bubble_cnt_r;
  logic [31:0] stall_cycles_r;
  logic [31:0] busy_early_s;
  logic        mult_hazard_s;
  logic        load_hazard_s;
  logic [4:0]  stall_s;
  logic [4:0]  flush_s;

  mult_scoreboard #(.STAGES(MULT_PPL_STAGE)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue      (mult_issue_ex_i),
    .rd         (mult_rd_ex_i),
    .busy       (mult_busy_o),
    .busy_early (busy_early_s),
    .wb_valid   (mult_wb_valid_o),
    .wb_addr    (mult_wb_addr_o)
  );

  // Hazard detection: pending multiplies block any register use; loads block reads only.
  always_comb begin
    mult_hazard_s = reg_hit(rs1_re_id_i, rs1_addr_id_i, busy_early_s)
                  | reg_hit(rs2_re_id_i, rs2_addr_id_i, busy_early_s)
                  | reg_hit(rd_we_id_i,  rd_addr_id_i,  busy_early_s);
    load_hazard_s = load_ex_i && (rd_addr_ex_i != 5'd0) &&
                    ((rs1_re_id_i && (rs1_addr_id_i == rd_addr_ex_i)) ||
                     (rs2_re_id_i && (rs2_addr_id_i == rd_addr_ex_i)));
  end

  // Stall/flush priority: reset, branch, redirect shadow, hazard, idle.
  always_comb begin
    stall_s = CTRL_NONE;
    flush_s = CTRL_NONE;
    if (!rst) begin
      stall_s = CTRL_NONE;
      flush_s = CTRL_NONE;
    end else if (branch_taken_ex_i) begin
      flush_s = FLUSH_BRANCH;
    end else if (state_r == ST_REDIRECT) begin
      flush_s = FLUSH_REDIRECT;
    end else if (mult_hazard_s || load_hazard_s) begin
      stall_s = STALL_HAZARD;
      flush_s = FLUSH_HAZARD;
    end else begin
      stall_s = CTRL_NONE;
      flush_s = CTRL_NONE;
    end
  end

  assign stall_o = stall_s & ~BACK_HALF_MASK;
  assign flush_o = flush_s & ~BACK_HALF_MASK;

  // Redirect FSM: a taken branch (re)loads the bubble counter; leave when it runs out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_RUN;
      bubble_cnt_r <= 8'd0;
    end else if (branch_taken_ex_i) begin
      state_r      <= BRANCH_NEXT;
      bubble_cnt_r <= BUBBLE_RELOAD;
    end else if (state_r == ST_REDIRECT) begin
      if (bubble_cnt_r <= 8'd1) begin
        state_r      <= ST_RUN;
        bubble_cnt_r <= 8'd0;
      end else begin
        bubble_cnt_r <= bubble_cnt_r - 8'd1;
      end
    end else begin
      state_r      <= ST_RUN;
      bubble_cnt_r <= 8'd0;
    end
  end

  // Stalled-cycle counter; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_r <= 32'd0;
    end else begin
      stall_cycles_r <= stall_cycles_r + {31'd0, stall_s[STG_PC]};
    end
  end

  assign stall_cycles_o = stall_cycles_r;

endmodule
